// File: rtl/change_dispense_ctrl_pkg.sv
// Shared types and constants for the change-dispense controller.
// Coin values are expressed in nickels.
package change_pkg;

   localparam int unsigned AmtWidth  = 4;
   localparam int unsigned CoinWidth = 3;

   localparam logic [CoinWidth-1:0] QUARTER = 3'd5;
   localparam logic [CoinWidth-1:0] DIME    = 3'd2;
   localparam logic [CoinWidth-1:0] NICKEL  = 3'd1;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StSelect,
      StDispense,
      StDone
   } state_t;

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Coin request handshake between the controller (master) and the coin mechanism (slave).
interface change_dispense_ctrl_if
   import change_pkg::*;
   ();

   logic                 dispense_valid;
   logic [CoinWidth-1:0] dispense_coin;
   logic                 dispense_ready;

   modport master (output dispense_valid, output dispense_coin, input dispense_ready);
   modport slave  (input dispense_valid, input dispense_coin, output dispense_ready);

endinterface

// File: rtl/change_dispense_ctrl_coin_select.sv
// Greedy coin chooser: largest coin that fits the amount owed and is in stock, else 0.
module coin_select
   import change_pkg::*;
#(
   parameter int unsigned INV_WIDTH = 2
) (
   input  logic [AmtWidth-1:0]  remaining_i,
   input  logic [INV_WIDTH-1:0] quarters_i,
   input  logic [INV_WIDTH-1:0] dimes_i,
   input  logic [INV_WIDTH-1:0] nickels_i,
   output logic [CoinWidth-1:0] coin_o
);

   always_comb begin
      coin_o = '0;
      if (remaining_i >= AmtWidth'(QUARTER) && quarters_i != '0) begin
         coin_o = QUARTER;
      end else if (remaining_i >= AmtWidth'(DIME) && dimes_i != '0) begin
         coin_o = DIME;
      end else if (remaining_i >= AmtWidth'(NICKEL) && nickels_i != '0) begin
         coin_o = NICKEL;
      end
   end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout controller: classifies a cost/paid pair, then pays change one coin at a
// time over a valid/ready handshake while tracking coin inventory.
module change_dispense_ctrl
   import change_pkg::*;
#(
   parameter int unsigned INV_WIDTH  = 2,
   parameter int unsigned INIT_COUNT = 3
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        start,
   input  logic [AmtWidth-1:0]         cost,
   input  logic [AmtWidth-1:0]         paid,
   input  logic                        refill,
   input  logic [INV_WIDTH-1:0]        refill_quarters,
   input  logic [INV_WIDTH-1:0]        refill_dimes,
   input  logic [INV_WIDTH-1:0]        refill_nickels,
   change_dispense_ctrl_if.master      disp,
   output logic                        busy,
   output logic                        done,
   output logic                        exact_amount,
   output logic                        cough_up_more,
   output logic                        short_change,
   output logic [AmtWidth-1:0]         remaining,
   output logic [INV_WIDTH-1:0]        quarters,
   output logic [INV_WIDTH-1:0]        dimes,
   output logic [INV_WIDTH-1:0]        nickels
);

   localparam logic [INV_WIDTH-1:0] InitCnt = INV_WIDTH'(INIT_COUNT);
   localparam logic [INV_WIDTH-1:0] CntOne  = INV_WIDTH'(1);

   state_t               state_q, state_d;
   logic [AmtWidth-1:0]  cost_q, cost_d, paid_q, paid_d, remaining_q, remaining_d;
   logic [CoinWidth-1:0] coin_q, coin_d, sel_coin;
   logic [INV_WIDTH-1:0] quarters_q, quarters_d, dimes_q, dimes_d, nickels_q, nickels_d;
   logic                 exact_q, exact_d, cough_q, cough_d, short_q, short_d;

   coin_select #(
      .INV_WIDTH (INV_WIDTH)
   ) u_coin_select (
      .remaining_i (remaining_q),
      .quarters_i  (quarters_q),
      .dimes_i     (dimes_q),
      .nickels_i   (nickels_q),
      .coin_o      (sel_coin)
   );

   always_comb begin
      state_d     = state_q;
      cost_d      = cost_q;
      paid_d      = paid_q;
      remaining_d = remaining_q;
      coin_d      = coin_q;
      quarters_d  = quarters_q;
      dimes_d     = dimes_q;
      nickels_d   = nickels_q;
      exact_d     = exact_q;
      cough_d     = cough_q;
      short_d     = short_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cost_d      = cost;
               paid_d      = paid;
               remaining_d = '0;
               exact_d     = 1'b0;
               cough_d     = 1'b0;
               short_d     = 1'b0;
               state_d     = StCheck;
            end else if (refill) begin
               quarters_d = refill_quarters;
               dimes_d    = refill_dimes;
               nickels_d  = refill_nickels;
            end
         end
         StCheck: begin
            if (paid_q < cost_q) begin
               cough_d     = 1'b1;
               remaining_d = '0;
               state_d     = StDone;
            end else if (paid_q == cost_q) begin
               exact_d = 1'b1;
               state_d = StDone;
            end else begin
               remaining_d = paid_q - cost_q;
               state_d     = StSelect;
            end
         end
         StSelect: begin
            if (sel_coin != '0) begin
               coin_d  = sel_coin;
               state_d = StDispense;
            end else begin
               short_d = 1'b1;
               state_d = StDone;
            end
         end
         StDispense: begin
            if (disp.dispense_ready) begin
               unique case (coin_q)
                  QUARTER: quarters_d = quarters_q - CntOne;
                  DIME:    dimes_d    = dimes_q - CntOne;
                  NICKEL:  nickels_d  = nickels_q - CntOne;
                  default: ;
               endcase
               remaining_d = remaining_q - AmtWidth'(coin_q);
               state_d     = (remaining_q == AmtWidth'(coin_q)) ? StDone : StSelect;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         cost_q      <= '0;
         paid_q      <= '0;
         remaining_q <= '0;
         coin_q      <= '0;
         quarters_q  <= InitCnt;
         dimes_q     <= InitCnt;
         nickels_q   <= InitCnt;
         exact_q     <= 1'b0;
         cough_q     <= 1'b0;
         short_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cost_q      <= cost_d;
         paid_q      <= paid_d;
         remaining_q <= remaining_d;
         coin_q      <= coin_d;
         quarters_q  <= quarters_d;
         dimes_q     <= dimes_d;
         nickels_q   <= nickels_d;
         exact_q     <= exact_d;
         cough_q     <= cough_d;
         short_q     <= short_d;
      end
   end

   assign disp.dispense_valid = (state_q == StDispense);
   assign disp.dispense_coin  = (state_q == StDispense) ? coin_q : '0;
   assign busy                = (state_q != StIdle);
   assign done                = (state_q == StDone);
   assign exact_amount        = exact_q;
   assign cough_up_more       = cough_q;
   assign short_change        = short_q;
   assign remaining           = remaining_q;
   assign quarters            = quarters_q;
   assign dimes               = dimes_q;
   assign nickels             = nickels_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed self-checking bench for change_dispense_ctrl.
module tb_change_dispense_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] cost  = '0;
   logic [3:0] paid  = '0;
   logic       refill = 1'b0;
   logic [1:0] rq = '0, rd = '0, rn = '0;
   logic       busy, done, exact_amount, cough_up_more, short_change;
   logic [3:0] remaining;
   logic [1:0] quarters, dimes, nickels;

   int n_total = 0;
   int n_pass  = 0;

   change_dispense_ctrl_if disp_if ();

   change_dispense_ctrl #(
      .INV_WIDTH  (2),
      .INIT_COUNT (3)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .cost            (cost),
      .paid            (paid),
      .refill          (refill),
      .refill_quarters (rq),
      .refill_dimes    (rd),
      .refill_nickels  (rn),
      .disp            (disp_if),
      .busy            (busy),
      .done            (done),
      .exact_amount    (exact_amount),
      .cough_up_more   (cough_up_more),
      .short_change    (short_change),
      .remaining       (remaining),
      .quarters        (quarters),
      .dimes           (dimes),
      .nickels         (nickels)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      disp_if.dispense_ready = 1'b0;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", busy); else n_pass++;
      n_total++; if (disp_if.dispense_valid !== 1'b0) $display("FAIL reset_valid: got %0d expected 0", disp_if.dispense_valid); else n_pass++;
      n_total++; if ({done, exact_amount, cough_up_more, short_change} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {done, exact_amount, cough_up_more, short_change}); else n_pass++;
      n_total++; if (remaining !== 4'd0) $display("FAIL reset_remaining: got %0d expected 0", remaining); else n_pass++;
      n_total++; if ({quarters, dimes, nickels} !== {2'd3, 2'd3, 2'd3}) $display("FAIL reset_inventory: got %0d/%0d/%0d expected 3/3/3", quarters, dimes, nickels); else n_pass++;
   endtask

   task automatic test_exact();
      logic seen_valid = 1'b0;
      cost = 4'd10; paid = 4'd10; start = 1'b1;
      step();
      start = 1'b0;
      seen_valid |= disp_if.dispense_valid;
      n_total++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL exact_k1: got done=%0d busy=%0d expected done=0 busy=1", done, busy); else n_pass++;
      step();
      seen_valid |= disp_if.dispense_valid;
      n_total++; if (done !== 1'b1) $display("FAIL exact_done_k2: got %0d expected 1", done); else n_pass++;
      n_total++; if (exact_amount !== 1'b1 || cough_up_more !== 1'b0) $display("FAIL exact_flag: got exact=%0d cough=%0d expected 1/0", exact_amount, cough_up_more); else n_pass++;
      n_total++; if (disp_if.dispense_coin !== 3'd0) $display("FAIL exact_coin_idle: got %0d expected 0", disp_if.dispense_coin); else n_pass++;
      step();
      n_total++; if (done !== 1'b0 || busy !== 1'b0 || exact_amount !== 1'b1) $display("FAIL exact_after: got done=%0d busy=%0d exact=%0d expected 0/0/1", done, busy, exact_amount); else n_pass++;
      n_total++; if (seen_valid !== 1'b0) $display("FAIL exact_no_valid: got %0d expected 0", seen_valid); else n_pass++;
      n_total++; if ({quarters, dimes, nickels} !== {2'd3, 2'd3, 2'd3}) $display("FAIL exact_inventory: got %0d/%0d/%0d expected 3/3/3", quarters, dimes, nickels); else n_pass++;
   endtask

   task automatic test_short_paid();
      cost = 4'd10; paid = 4'd5; start = 1'b1;
      step();
      start = 1'b0;
      step();
      n_total++; if (done !== 1'b1) $display("FAIL short_paid_done_k2: got %0d expected 1", done); else n_pass++;
      n_total++; if (cough_up_more !== 1'b1 || exact_amount !== 1'b0) $display("FAIL short_paid_flags: got cough=%0d exact=%0d expected 1/0", cough_up_more, exact_amount); else n_pass++;
      n_total++; if (remaining !== 4'd0) $display("FAIL short_paid_remaining: got %0d expected 0", remaining); else n_pass++;
      step();
   endtask

   task automatic test_greedy();
      int coins[$];
      int exp_c[4] = '{5, 2, 1, 1};
      int first_v = -1;
      int done_cyc = -1;
      refill = 1'b1; rq = 2'd1; rd = 2'd1; rn = 2'd3;
      step();
      refill = 1'b0;
      n_total++; if ({quarters, dimes, nickels} !== {2'd1, 2'd1, 2'd3}) $display("FAIL greedy_refill: got %0d/%0d/%0d expected 1/1/3", quarters, dimes, nickels); else n_pass++;
      disp_if.dispense_ready = 1'b1;
      cost = 4'd5; paid = 4'd14; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 14 && done_cyc < 0; c++) begin
         if (disp_if.dispense_valid) begin
            if (first_v < 0) first_v = c;
            coins.push_back(int'(disp_if.dispense_coin));
         end
         if (done) done_cyc = c;
         else step();
      end
      n_total++; if (first_v !== 3) $display("FAIL greedy_first_valid: got cycle %0d expected 3", first_v); else n_pass++;
      n_total++; if (done_cyc !== 10) $display("FAIL greedy_done_cycle: got %0d expected 10", done_cyc); else n_pass++;
      n_total++; if (coins.size() !== 4) $display("FAIL greedy_coin_count: got %0d expected 4", coins.size()); else n_pass++;
      for (int i = 0; i < 4 && i < coins.size(); i++) begin
         n_total++; if (coins[i] !== exp_c[i]) $display("FAIL greedy_coin%0d: got %0d expected %0d", i, coins[i], exp_c[i]); else n_pass++;
      end
      n_total++; if (remaining !== 4'd0 || short_change !== 1'b0) $display("FAIL greedy_status: got rem=%0d short=%0d expected 0/0", remaining, short_change); else n_pass++;
      n_total++; if ({quarters, dimes, nickels} !== {2'd0, 2'd0, 2'd1}) $display("FAIL greedy_inventory: got %0d/%0d/%0d expected 0/0/1", quarters, dimes, nickels); else n_pass++;
      disp_if.dispense_ready = 1'b0;
      step();
   endtask

   task automatic test_short_change();
      int coins[$];
      int done_cyc = -1;
      refill = 1'b1; rq = 2'd0; rd = 2'd0; rn = 2'd1;
      step();
      refill = 1'b0;
      disp_if.dispense_ready = 1'b1;
      cost = 4'd0; paid = 4'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
         if (disp_if.dispense_valid) coins.push_back(int'(disp_if.dispense_coin));
         if (done) done_cyc = c;
         else step();
      end
      n_total++; if (done_cyc !== 5) $display("FAIL short_change_done_cycle: got %0d expected 5", done_cyc); else n_pass++;
      n_total++; if (coins.size() !== 1) $display("FAIL short_change_coin_count: got %0d expected 1", coins.size()); else n_pass++;
      if (coins.size() > 0) begin
         n_total++; if (coins[0] !== 1) $display("FAIL short_change_coin: got %0d expected 1", coins[0]); else n_pass++;
      end
      n_total++; if (short_change !== 1'b1 || remaining !== 4'd2) $display("FAIL short_change_status: got short=%0d rem=%0d expected 1/2", short_change, remaining); else n_pass++;
      n_total++; if (nickels !== 2'd0) $display("FAIL short_change_nickels: got %0d expected 0", nickels); else n_pass++;
      disp_if.dispense_ready = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      refill = 1'b1; rq = 2'd3; rd = 2'd3; rn = 2'd3;
      step();
      refill = 1'b0;
      disp_if.dispense_ready = 1'b0;
      cost = 4'd0; paid = 4'd5; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         n_total++; if (disp_if.dispense_valid !== 1'b1 || disp_if.dispense_coin !== 3'd5) $display("FAIL bp_hold%0d: got valid=%0d coin=%0d expected 1/5", i, disp_if.dispense_valid, disp_if.dispense_coin); else n_pass++;
         n_total++; if (quarters !== 2'd3) $display("FAIL bp_no_decrement%0d: got %0d expected 3", i, quarters); else n_pass++;
         if (i == 1) begin
            cost = 4'd15; paid = 4'd0; start = 1'b1;
         end
         step();
         start = 1'b0;
      end
      disp_if.dispense_ready = 1'b1;
      step();
      disp_if.dispense_ready = 1'b0;
      n_total++; if (done !== 1'b1 || disp_if.dispense_valid !== 1'b0) $display("FAIL bp_done: got done=%0d valid=%0d expected 1/0", done, disp_if.dispense_valid); else n_pass++;
      n_total++; if (quarters !== 2'd2) $display("FAIL bp_one_decrement: got %0d expected 2", quarters); else n_pass++;
      n_total++; if (cough_up_more !== 1'b0 || remaining !== 4'd0) $display("FAIL bp_start_ignored: got cough=%0d rem=%0d expected 0/0", cough_up_more, remaining); else n_pass++;
      step();
      n_total++; if (busy !== 1'b0) $display("FAIL bp_idle_after: got %0d expected 0", busy); else n_pass++;
   endtask

   task automatic test_mid_reset();
      cost = 4'd0; paid = 4'd2; start = 1'b1;
      step();
      start = 1'b0;
      refill = 1'b1; rq = 2'd1; rd = 2'd1; rn = 2'd1;
      step();
      step();
      n_total++; if (disp_if.dispense_valid !== 1'b1 || disp_if.dispense_coin !== 3'd2) $display("FAIL mid_dispense: got valid=%0d coin=%0d expected 1/2", disp_if.dispense_valid, disp_if.dispense_coin); else n_pass++;
      n_total++; if ({quarters, dimes, nickels} !== {2'd2, 2'd3, 2'd3}) $display("FAIL refill_while_busy: got %0d/%0d/%0d expected 2/3/3", quarters, dimes, nickels); else n_pass++;
      refill = 1'b0;
      reset = 1'b1;
      disp_if.dispense_ready = 1'b1;
      step();
      reset = 1'b0;
      disp_if.dispense_ready = 1'b0;
      n_total++; if (disp_if.dispense_valid !== 1'b0 || busy !== 1'b0) $display("FAIL mid_reset_idle: got valid=%0d busy=%0d expected 0/0", disp_if.dispense_valid, busy); else n_pass++;
      n_total++; if ({quarters, dimes, nickels} !== {2'd3, 2'd3, 2'd3}) $display("FAIL mid_reset_inventory: got %0d/%0d/%0d expected 3/3/3", quarters, dimes, nickels); else n_pass++;
      step();
      n_total++; if (busy !== 1'b0 || remaining !== 4'd0) $display("FAIL mid_reset_after: got busy=%0d rem=%0d expected 0/0", busy, remaining); else n_pass++;
   endtask

   initial begin
      disp_if.dispense_ready = 1'b0;
      test_reset();
      test_exact();
      test_short_paid();
      test_greedy();
      test_short_change();
      test_backpressure();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/change_dispense_ctrl.md
# change_dispense_ctrl

Sequential controller for a vending transaction's change payout. It accepts a cost/paid pair in nickel units and classifies the transaction as short-paid, exact or change-owed. For change-owed transactions it issues coins one at a time, greedy largest-first, over a valid/ready handshake to the coin dispenser mechanism. It owns the coin inventory counters, which are refilled from the service port between transactions.

## Interface
- `INV_WIDTH`, 2: width of each coin inventory counter.
- `INIT_COUNT`, 3: value loaded into every inventory counter on reset.
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a transaction; accepted only in IDLE.
- `cost` in 4: price, nickels.
- `paid` in 4: amount inserted, nickels.
- `refill` in 1: load inventory; accepted only in IDLE with `start` low.
- `refill_quarters`, `refill_dimes`, `refill_nickels` in INV_WIDTH each: new counts.
- `dispense_valid` out 1: coin request pending.
- `dispense_coin` out 3: coin value in nickels (5 quarter, 2 dime, 1 nickel); 0 when not valid.
- `dispense_ready` in 1: dispenser accepts coin.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at transaction end.
- `exact_amount` out 1: status flag; held from `done` until the next accepted `start`.
- `cough_up_more` out 1: status flag; held on the same rule.
- `short_change` out 1: status flag; held on the same rule.
- `remaining` out 4: change still owed, in nickels; held on the same rule.
- `quarters`, `dimes`, `nickels` out INV_WIDTH each: current inventory.

## Operation
- **States:** IDLE, CHECK, SELECT, DISPENSE, DONE.
- **IDLE, `start` high:**
  - Register `cost` and `paid`.
  - Clear all status flags and `remaining`.
  - Go to CHECK.
- **IDLE, `refill` high (and `start` low):** overwrite all three counters. `refill` outside IDLE is ignored.
- **CHECK:**
  - `paid < cost`: set `cough_up_more`, `remaining` = 0, go to DONE.
  - `paid == cost`: set `exact_amount`, go to DONE.
  - Otherwise: `remaining` = `paid - cost` (4-bit, no wrap possible), go to SELECT.
- **SELECT:** pick the largest coin with value ≤ `remaining` and inventory count > 0.
  - A coin is found: latch it, go to DISPENSE.
  - No coin found: set `short_change`, keep `remaining`, go to DONE.
- **DISPENSE:**
  - Hold `dispense_valid` high with `dispense_coin` stable until `dispense_ready`.
  - On the handshake cycle, decrement that coin's counter and subtract its value from `remaining`.
  - If the new `remaining` is 0, go to DONE; otherwise go to SELECT.
- **DONE:** `done` high for one cycle, then go to IDLE.
- **Ignored inputs:** `start` while `busy` is ignored. `dispense_ready` outside DISPENSE is ignored.
- **Counter bounds:** counters never underflow, because SELECT requires count > 0. Counters are never incremented except by refill.
- **Greedy non-optimality is by design:** change 3 with no nickels yields a dime, then `short_change` with `remaining` = 1.

## Timing
- **Reset:**
  - State IDLE; all outputs 0 except the inventory outputs, which equal `INIT_COUNT`.
  - Reset mid-transaction abandons it and drops any pending coin without a decrement.
- **Short-paid or exact:** `start` sampled at edge k gives `done` high in cycle k+2.
- **Change owed:**
  - First `dispense_valid` is high in cycle k+3.
  - Each coin takes one SELECT cycle plus at least one DISPENSE cycle.
  - With `dispense_ready` tied high, N coins give `done` at cycle k+2+2N.
- **Status outputs:** update on the same edge that enters DONE, so they are valid while `done` is high.
- **Inventory outputs:** decrement is visible the cycle after the handshake.
- **Refill:** visible the cycle after `refill` is accepted.

## Structure
- **Package `change_pkg`:**
  - Coin-value constants QUARTER=5, DIME=2, NICKEL=1.
  - `state_t` enum with the five states.
  - Amount width 4.
- **Sub-module `coin_select`:** combinational. Inputs `remaining` and the three counts; outputs the chosen coin value, or 0 for none. Instantiated once and used in SELECT.
- **Top level:** FSM, amount registers, inventory counters and status registers.

## Test plan
- **Reset and exact:** reset, then start cost=10, paid=10 → `done` at k+2, `exact_amount`=1, no `dispense_valid`, inventory stays 3/3/3.
- **Short-paid:** cost=10, paid=5 → `cough_up_more`=1, `remaining`=0, `done` at k+2.
- **Greedy order:** refill 1/1/3, cost=5, paid=14 (change 9) → coins 5, 2, 1, 1; `remaining`=0; inventory 0/0/1; `done` at k+10 with ready tied high.
- **Short change:** refill 0/0/1, change 3 → one nickel, then `short_change`=1, `remaining`=2, nickels=0.
- **Backpressure:** hold `dispense_ready` low 4 cycles → `dispense_valid` and coin stable throughout; exactly one decrement after ready rises; `start` pulsed mid-transaction is ignored.
- **Mid-transaction reset and refill gating:** reset asserted during DISPENSE → IDLE, counts = `INIT_COUNT`, `dispense_valid`=0 next cycle; `refill` while busy → counts unchanged.
